// File: rtl/sprite_spawner.sv
// Straight-line sprite motion: moves (hoffset, voffset) from SRC to DST over STEP ticks, then idles.
// Latency: outputs registered, one edge from en to the first in-flight value; flight lasts STEP+1 edges.
// Backpressure: none; en is a request sampled only in IDLE and ignored for the whole flight.
//
// Ports:
//   clk     - tick clock (frame strobe in the game); all state changes on its rising edge
//   rst     - synchronous active-high reset, overrides everything including a flight in progress
//   en      - spawn request
//   hoffset - current horizontal offset, signed HWIDTH bits
//   voffset - current vertical offset, signed VWIDTH bits
//   active  - high while the object is in flight (used for mutual exclusion between spawners)
module sprite_spawner #(
    parameter int                        HWIDTH = 12,
    parameter int                        VWIDTH = 12,
    parameter logic signed [HWIDTH-1:0]  HSRC   = '0,
    parameter logic signed [VWIDTH-1:0]  VSRC   = VWIDTH'(-140),
    parameter logic signed [HWIDTH-1:0]  HDST   = '0,
    parameter logic signed [VWIDTH-1:0]  VDST   = VWIDTH'(220),
    parameter int                        STEP   = 32    // power of two, >= 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    output logic signed [HWIDTH-1:0] hoffset,
    output logic signed [VWIDTH-1:0] voffset,
    output logic                     active
);

    localparam int SH  = $clog2(STEP);
    localparam int KW  = SH + 1;              // holds 0..STEP inclusive
    localparam int HPW = HWIDTH + 1 + KW;     // full-width product, cannot overflow
    localparam int VPW = VWIDTH + 1 + KW;

    typedef enum logic {IDLE, MOVE} phase_t;

    phase_t          phase;
    logic [KW-1:0]   k;
    logic [KW-1:0]   k_next;

    // Deltas carry one extra bit so DST-SRC never overflows.
    logic signed [HWIDTH:0]     hdelta;
    logic signed [VWIDTH:0]     vdelta;
    logic signed [HPW-1:0]      hd_ext, hk_ext, hprod, hquot;
    logic signed [VPW-1:0]      vd_ext, vk_ext, vprod, vquot;
    logic signed [HWIDTH-1:0]   hpos;
    logic signed [VWIDTH-1:0]   vpos;

    assign k_next = k + KW'(1);

    assign hdelta = {HDST[HWIDTH-1], HDST} - {HSRC[HWIDTH-1], HSRC};
    assign vdelta = {VDST[VWIDTH-1], VDST} - {VSRC[VWIDTH-1], VSRC};

    // Position for the step being entered. The arithmetic shift of the
    // signed product gives floor division (toward -inf), so negative
    // deltas round down, and k=STEP lands exactly on DST.
    always_comb begin
        hd_ext  = HPW'(hdelta);
        hk_ext  = HPW'({1'b0, k_next});
        hprod   = hd_ext * hk_ext;
        hquot   = hprod >>> SH;
        hpos    = HSRC + hquot[HWIDTH-1:0];

        vd_ext  = VPW'(vdelta);
        vk_ext  = VPW'({1'b0, k_next});
        vprod   = vd_ext * vk_ext;
        vquot   = vprod >>> SH;
        vpos    = VSRC + vquot[VWIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase   <= IDLE;
            k       <= '0;
            active  <= 1'b0;
            hoffset <= HSRC;
            voffset <= VSRC;
        end else begin
            case (phase)
                IDLE: begin
                    // Outputs already sit at SRC; only active changes on launch.
                    k       <= '0;
                    hoffset <= HSRC;
                    voffset <= VSRC;
                    if (en) begin
                        phase  <= MOVE;
                        active <= 1'b1;
                    end else begin
                        active <= 1'b0;
                    end
                end
                MOVE: begin
                    if (k == KW'(STEP)) begin
                        // Final edge: en is deliberately not looked at here,
                        // so a restart always costs one idle edge.
                        phase   <= IDLE;
                        k       <= '0;
                        active  <= 1'b0;
                        hoffset <= HSRC;
                        voffset <= VSRC;
                    end else begin
                        k       <= k_next;
                        hoffset <= hpos;
                        voffset <= vpos;
                    end
                end
                default: begin
                    phase   <= IDLE;
                    k       <= '0;
                    active  <= 1'b0;
                    hoffset <= HSRC;
                    voffset <= VSRC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_spawner.sv
// Bench for sprite_spawner: three parameterisations driven by shared en/rst,
// each compared against a flight-timeline model (start edge + integer floor division).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_sprite_spawner;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;

    logic signed [11:0] hq [3];
    logic signed [11:0] vq [3];
    logic               aq [3];

    // Instance 0: defaults. 1: negative horizontal delta. 2: STEP=2.
    localparam int P_HS [3] = '{0, -80, 0};
    localparam int P_HD [3] = '{0, -120, 0};
    localparam int P_VS [3] = '{-140, -140, 0};
    localparam int P_VD [3] = '{220, 220, 5};
    localparam int P_ST [3] = '{32, 32, 2};

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sprite_spawner u0 (
        .clk(clk), .rst(rst), .en(en),
        .hoffset(hq[0]), .voffset(vq[0]), .active(aq[0])
    );

    sprite_spawner #(
        .HSRC(-12'sd80), .HDST(-12'sd120)
    ) u1 (
        .clk(clk), .rst(rst), .en(en),
        .hoffset(hq[1]), .voffset(vq[1]), .active(aq[1])
    );

    sprite_spawner #(
        .VSRC(12'sd0), .VDST(12'sd5), .STEP(2)
    ) u2 (
        .clk(clk), .rst(rst), .en(en),
        .hoffset(hq[2]), .voffset(vq[2]), .active(aq[2])
    );

    // Model: each instance remembers the edge number its flight started on
    // (-1 when idle). Step k after edge n is n - start. A flight started at
    // edge s occupies edges s..s+STEP and ends on edge s+STEP+1.
    int ecnt = 0;
    int start [3] = '{-1, -1, -1};

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst)
                start[i] <= -1;
            else if (start[i] < 0) begin
                if (en) start[i] <= ecnt;
            end else if (ecnt - start[i] == P_ST[i] + 1)
                start[i] <= -1;
        end
        ecnt <= ecnt + 1;
    end

    function automatic logic signed [11:0] exp_pos(int src, int dst, int stp, int k);
        int num, q, p;
        num = (dst - src) * k;
        q   = num / stp;
        if ((num % stp) != 0 && num < 0) q = q - 1;
        p   = src + q;
        p   = ((p % 4096) + 4096) % 4096;
        return 12'(p);
    endfunction

    // Expected {active, hoffset, voffset} after the most recent edge.
    function automatic logic [24:0] exp_of(int i);
        logic a;
        int   k;
        a = (start[i] >= 0);
        k = a ? (ecnt - 1 - start[i]) : 0;
        return {a, exp_pos(P_HS[i], P_HD[i], P_ST[i], k), exp_pos(P_VS[i], P_VD[i], P_ST[i], k)};
    endfunction

    task automatic tick(input logic e, input logic r);
        en  = e;
        rst = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        for (int n = 0; n < 5; n++) begin
            tick(1'b0, 1'b0);
            checks++;
            if (aq[0] !== 1'b0 || hq[0] !== 12'sd0 || vq[0] !== 12'hF74) begin
                failures++;
                $display("FAIL reset_hold edge%0d got a=%b h=%0d v=%h want a=0 h=0 v=f74", n, aq[0], hq[0], vq[0]);
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if ({aq[i], hq[i], vq[i]} !== exp_of(i)) begin
                    failures++;
                    $display("FAIL reset_model inst%0d got %h want %h", i, {aq[i], hq[i], vq[i]}, exp_of(i));
                end
            end
        end
    endtask

    task automatic test_single_flight;
        int act_edges = 0;
        for (int e = 0; e < 40; e++) begin
            tick(e == 0, 1'b0);
            if (aq[0] === 1'b1) act_edges++;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if ({aq[i], hq[i], vq[i]} !== exp_of(i)) begin
                    failures++;
                    $display("FAIL flight_model e%0d inst%0d got %h want %h", e, i, {aq[i], hq[i], vq[i]}, exp_of(i));
                end
            end
            checks++;
            if (hq[0] !== 12'sd0) begin
                failures++;
                $display("FAIL flight_h_zero e%0d got %0d want 0", e, hq[0]);
            end
            if (e == 0 || e == 1 || e == 16 || e == 32 || e == 33) begin
                logic signed [11:0] wv;
                logic               wa;
                wv = (e == 1) ? -12'sd129 : (e == 16) ? 12'sd40 : (e == 32) ? 12'sd220 : -12'sd140;
                wa = (e != 33);
                checks++;
                if (aq[0] !== wa || vq[0] !== wv) begin
                    failures++;
                    $display("FAIL flight_point e%0d got a=%b v=%0d want a=%b v=%0d", e, aq[0], vq[0], wa, wv);
                end
            end
        end
        checks++;
        if (act_edges != 33) begin
            failures++;
            $display("FAIL flight_active_len got %0d want 33", act_edges);
        end
    endtask

    task automatic test_negative_delta;
        for (int e = 0; e < 36; e++) begin
            tick(e == 0, 1'b0);
            if (e == 0 || e == 1 || e == 16 || e == 32) begin
                logic signed [11:0] wh;
                wh = (e == 1) ? -12'sd82 : (e == 16) ? -12'sd100 : (e == 32) ? -12'sd120 : -12'sd80;
                checks++;
                if (hq[1] !== wh || aq[1] !== 1'b1) begin
                    failures++;
                    $display("FAIL negdelta_point e%0d got a=%b h=%0d want a=1 h=%0d", e, aq[1], hq[1], wh);
                end
            end
        end
    endtask

    task automatic test_step2;
        logic               wa [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic signed [11:0] wv [5] = '{12'sd0, 12'sd2, 12'sd5, 12'sd0, 12'sd0};
        for (int e = 0; e < 5; e++) begin
            tick(e == 0, 1'b0);
            checks++;
            if (aq[2] !== wa[e] || vq[2] !== wv[e]) begin
                failures++;
                $display("FAIL step2_seq e%0d got a=%b v=%0d want a=%b v=%0d", e, aq[2], vq[2], wa[e], wv[e]);
            end
        end
        for (int e = 0; e < 36; e++) tick(1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        for (int e = 0; e < 80; e++) begin
            logic wa;
            tick(1'b1, 1'b0);
            wa = ((e % 34) != 33);
            checks++;
            if (aq[0] !== wa || (!wa && vq[0] !== -12'sd140)) begin
                failures++;
                $display("FAIL b2b_pattern e%0d got a=%b v=%0d want a=%b", e, aq[0], vq[0], wa);
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if ({aq[i], hq[i], vq[i]} !== exp_of(i)) begin
                    failures++;
                    $display("FAIL b2b_model e%0d inst%0d got %h want %h", e, i, {aq[i], hq[i], vq[i]}, exp_of(i));
                end
            end
        end
        for (int e = 0; e < 36; e++) tick(1'b0, 1'b0);
    endtask

    task automatic test_en_ignored;
        for (int e = 0; e < 36; e++) begin
            tick(e == 0 || e == 5 || e == 20 || e == 33, 1'b0);
            if (e == 32 || e == 33 || e == 34) begin
                checks++;
                if (aq[0] !== (e == 32)) begin
                    failures++;
                    $display("FAIL en_ignored e%0d got a=%b want %b", e, aq[0], (e == 32));
                end
            end
        end
    endtask

    task automatic test_reset_mid_flight;
        for (int e = 0; e <= 10; e++) tick(e == 0, 1'b0);
        checks++;
        if (aq[0] !== 1'b1 || vq[0] !== exp_pos(-140, 220, 32, 10)) begin
            failures++;
            $display("FAIL midrst_k10 got a=%b v=%0d want a=1 v=%0d", aq[0], vq[0], exp_pos(-140, 220, 32, 10));
        end
        tick(1'b1, 1'b1);
        checks++;
        if (aq[0] !== 1'b0 || vq[0] !== -12'sd140 || aq[1] !== 1'b0 || hq[1] !== -12'sd80) begin
            failures++;
            $display("FAIL midrst_clear got a=%b v=%0d a1=%b h1=%0d want 0 -140 0 -80", aq[0], vq[0], aq[1], hq[1]);
        end
        tick(1'b1, 1'b0);
        checks++;
        if (aq[0] !== 1'b1 || vq[0] !== -12'sd140) begin
            failures++;
            $display("FAIL midrst_restart got a=%b v=%0d want a=1 v=-140", aq[0], vq[0]);
        end
        tick(1'b0, 1'b0);
        checks++;
        if (aq[0] !== 1'b1 || vq[0] !== -12'sd129) begin
            failures++;
            $display("FAIL midrst_k1 got a=%b v=%0d want a=1 v=-129", aq[0], vq[0]);
        end
        for (int e = 0; e < 36; e++) tick(1'b0, 1'b0);
    endtask

    task automatic test_random;
        for (int e = 0; e < 600; e++) begin
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 79) == 0);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if ({aq[i], hq[i], vq[i]} !== exp_of(i)) begin
                    failures++;
                    $display("FAIL random_model e%0d inst%0d got %h want %h", e, i, {aq[i], hq[i], vq[i]}, exp_of(i));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_flight();
        test_negative_delta();
        test_step2();
        test_back_to_back();
        test_en_ignored();
        test_reset_mid_flight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
